avalon_cmd_master: RTL and testbench



---
 rtl/avalon_cmd_master_pkg.sv | 40 ++++
 rtl/avalon_cmd_master_if.sv | 41 ++++
 rtl/avalon_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_avalon_cmd_master.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_cmd_master_pkg.sv
// Shared definitions for the UART-command to Avalon-MM master: command and
// response codes, frame byte counts and the parser state encoding.
package avalon_cmd_master_pkg;

  // Bus and byte widths
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;

  // Command bytes opening a frame
  localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

  // Response bytes
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

  // Payload byte counts following the command byte
  localparam int unsigned ADDR_BYTES = 2;
  localparam int unsigned DATA_BYTES = 4;

  // Number of bytes in a read response (one full word)
  localparam int unsigned RD_RSP_BYTES = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_BUS_WR  = 3'd3,
    ST_BUS_RD  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RESP    = 3'd6
  } state_e;

  // True for the states in which the parser takes bytes from the receiver
  function automatic logic rx_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/avalon_cmd_master_if.sv
// Byte-stream, Avalon-MM and status signals of the command master, grouped so
// the master and its environment connect through one bundle.
interface avalon_cmd_master_if;
  import avalon_cmd_master_pkg::*;

  // UART receive stream
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  // UART transmit stream
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Avalon-MM master side
  logic [ADDR_W-1:0] avm_address;
  logic [WORD_W-1:0] avm_writedata;
  logic              avm_write;
  logic              avm_read;
  logic [WORD_W-1:0] avm_readdata;

  // Status
  logic              busy;
  logic              frame_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, avm_readdata,
    output rx_ready, tx_data, tx_valid,
    output avm_address, avm_writedata, avm_write, avm_read,
    output busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, avm_readdata,
    input  rx_ready, tx_data, tx_valid,
    input  avm_address, avm_writedata, avm_write, avm_read,
    input  busy, frame_err
  );

endinterface

// File: rtl/avalon_cmd_master.sv
// Parses 'W'/'R' command frames from the UART byte stream, performs one
// single-word Avalon-MM access per frame and streams the reply ('K', the four
// read-data bytes MSB first, or '?' for an unknown command) back to the UART.
module avalon_cmd_master
  import avalon_cmd_master_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  avalon_cmd_master_if.master bus
);

  // Last RD_WAIT count before readdata is valid (latency 1..4 fits 2 bits)
  localparam logic [1:0]  LAT_LAST    = 2'(READ_LATENCY - 1);
  // Idle-count value whose next idle cycle trips the timeout
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_ENABLE   = (TIMEOUT_CYCLES != 0);
  localparam logic [2:0]  ADDR_LAST   = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]  DATA_LAST   = 3'(DATA_BYTES - 1);
  localparam logic [2:0]  RD_RSP_CNT  = 3'(RD_RSP_BYTES);

  state_e              r_state;
  logic                r_is_wr;
  logic [2:0]          r_byte_cnt;
  logic [1:0]          r_lat_cnt;
  logic [31:0]         r_to_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_resp_sr;
  logic [2:0]          r_resp_cnt;
  logic                r_avm_write;
  logic                r_avm_read;
  logic                r_tx_valid;
  logic                r_busy;
  logic                r_frame_err;

  logic                w_rx_ready;
  logic                w_rx_fire;
  logic                w_tx_fire;
  logic                w_in_frame;
  logic                w_timeout;

  // rx_ready follows the registered state; forced low while rst is held so
  // nothing is accepted during reset and it rises on the first cycle after.
  assign w_rx_ready = rx_state(r_state) && !rst;
  assign w_rx_fire  = bus.rx_valid && w_rx_ready;
  assign w_tx_fire  = r_tx_valid && bus.tx_ready;
  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_timeout  = TO_ENABLE && w_in_frame && !w_rx_fire && (r_to_cnt == TO_LAST);

  assign bus.rx_ready      = w_rx_ready;
  assign bus.tx_data       = r_resp_sr[WORD_W-1 -: BYTE_W];
  assign bus.tx_valid      = r_tx_valid;
  assign bus.avm_address   = r_addr;
  assign bus.avm_writedata = r_wdata;
  assign bus.avm_write     = r_avm_write;
  assign bus.avm_read      = r_avm_read;
  assign bus.busy          = r_busy;
  assign bus.frame_err     = r_frame_err;

  // Inter-byte idle counter: runs only inside a frame, restarts on each byte
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (TO_ENABLE && w_in_frame && !w_rx_fire && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Frame parser, bus sequencer and response streamer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_wr     <= 1'b0;
      r_byte_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_sr   <= '0;
      r_resp_cnt  <= '0;
      r_avm_write <= 1'b0;
      r_avm_read  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Strobes and the error flag are single-cycle pulses by default
      r_avm_write <= 1'b0;
      r_avm_read  <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_rx_fire) begin
            r_busy <= 1'b1;
            if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
              r_is_wr    <= (bus.rx_data == CMD_WR);
              r_byte_cnt <= '0;
              r_state    <= ST_ADDR;
            end else begin
              r_resp_sr   <= {RSP_ERR, 24'h0};
              r_resp_cnt  <= 3'd1;
              r_tx_valid  <= 1'b1;
              r_frame_err <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
        end

        ST_ADDR: begin
          if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_rx_fire) begin
            r_addr <= {r_addr[ADDR_W-BYTE_W-1:0], bus.rx_data};
            if (r_byte_cnt == ADDR_LAST) begin
              r_byte_cnt <= '0;
              if (r_is_wr) begin
                r_state <= ST_DATA;
              end else begin
                r_avm_read <= 1'b1;
                r_state    <= ST_BUS_RD;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end
        end

        ST_DATA: begin
          if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_rx_fire) begin
            r_wdata <= {r_wdata[WORD_W-BYTE_W-1:0], bus.rx_data};
            if (r_byte_cnt == DATA_LAST) begin
              r_byte_cnt  <= '0;
              r_avm_write <= 1'b1;
              r_state     <= ST_BUS_WR;
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end
        end

        ST_BUS_WR: begin
          r_resp_sr  <= {RSP_ACK, 24'h0};
          r_resp_cnt <= 3'd1;
          r_tx_valid <= 1'b1;
          r_state    <= ST_RESP;
        end

        ST_BUS_RD: begin
          r_lat_cnt <= '0;
          r_state   <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_resp_sr  <= bus.avm_readdata;
            r_resp_cnt <= RD_RSP_CNT;
            r_tx_valid <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end

        ST_RESP: begin
          if (w_tx_fire) begin
            r_resp_sr  <= {r_resp_sr[WORD_W-BYTE_W-1:0], 8'h00};
            r_resp_cnt <= r_resp_cnt - 3'd1;
            if (r_resp_cnt == 3'd1) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Scoreboard bench for avalon_cmd_master: stimulus pushes the expected bus
// accesses, reply bytes and error pulses; a negedge monitor pops and compares.
module tb_avalon_cmd_master;
  import avalon_cmd_master_pkg::*;

  localparam int unsigned RL = 1;
  localparam int unsigned TO = 100;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  avalon_cmd_master_if bus ();

  avalon_cmd_master #(
    .READ_LATENCY  (RL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  acc_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  int          exp_ferr = 0;

  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] slv_mem [logic [15:0]];
  logic        bp_hold = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Slave register file with a one-cycle read pipeline; readdata is garbage
  // outside the valid cycle so a wrongly timed capture is visible.
  always @(posedge clk) begin
    if (bus.avm_write) slv_mem[bus.avm_address] = bus.avm_writedata;
    if (bus.avm_read)
      bus.avm_readdata <= slv_mem.exists(bus.avm_address) ? slv_mem[bus.avm_address]
                                                           : dflt(bus.avm_address);
    else
      bus.avm_readdata <= 32'hDEAD_BEEF;
  end

  // Transmit sink: random readiness unless the bench is holding it off
  always @(posedge clk) begin
    #1 bus.tx_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_ferr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0; prev_ferr = 1'b0;
    end else begin
      if (bus.tx_valid) begin
        chkb("rx_ready_low_in_resp", bus.rx_ready, 1'b0);
        chkb("busy_in_resp", bus.busy, 1'b1);
      end
      if (prev_stall) begin
        chkb("tx_hold_valid", bus.tx_valid, 1'b1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chkb("tx_byte_expected", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.avm_write || bus.avm_read) begin
        acc_t e;
        chkb("strobe_expected", exp_bus.size() != 0, 1'b1);
        chkb("strobe_not_both", bus.avm_write && bus.avm_read, 1'b0);
        chkb("strobe_vs_ferr", bus.frame_err, 1'b0);
        chkb("busy_in_strobe", bus.busy, 1'b1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          chkb("strobe_kind", bus.avm_write, e.wr);
          chk("strobe_addr", 32'(bus.avm_address), 32'(e.addr));
          if (e.wr) chk("strobe_wdata", bus.avm_writedata, e.data);
        end
      end
      if (bus.avm_write) chkb("wr_single_cycle", prev_wr, 1'b0);
      if (bus.avm_read)  chkb("rd_single_cycle", prev_rd, 1'b0);
      if (bus.frame_err) begin
        chkb("ferr_expected", exp_ferr > 0, 1'b1);
        chkb("ferr_single_cycle", prev_ferr, 1'b0);
        if (exp_ferr > 0) exp_ferr--;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_wr    = bus.avm_write;
      prev_rd    = bus.avm_read;
      prev_ferr  = bus.frame_err;
    end
  end

  // Offer one byte after an optional gap; returns at posedge+1 after acceptance
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    logic ok;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 5000) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    if (!ok) chkb("rx_accept_timeout", ok, 1'b1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int maxgap);
    exp_bus.push_back('{wr: 1'b1, addr: a, data: d});
    exp_tx.push_back(RSP_ACK);
    ref_mem[a] = d;
    send_byte(CMD_WR, $urandom_range(0, maxgap));
    send_byte(a[15:8], $urandom_range(0, maxgap));
    send_byte(a[7:0], $urandom_range(0, maxgap));
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] dd;
      dd = d >> (8 * i);
      send_byte(dd[7:0], $urandom_range(0, maxgap));
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int maxgap);
    logic [31:0] v;
    v = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    exp_bus.push_back('{wr: 1'b0, addr: a, data: 32'h0});
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] vv;
      vv = v >> (8 * i);
      exp_tx.push_back(vv[7:0]);
    end
    send_byte(CMD_RD, $urandom_range(0, maxgap));
    send_byte(a[15:8], $urandom_range(0, maxgap));
    send_byte(a[7:0], $urandom_range(0, maxgap));
  endtask

  task automatic do_bad(input logic [7:0] b);
    exp_tx.push_back(RSP_ERR);
    exp_ferr++;
    send_byte(b, $urandom_range(0, 2));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || exp_ferr != 0 || bus.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chkb("idle_reached", n < 5000, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chkb({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    chkb({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'h0);
    chkb({tag, "_avm_write"}, bus.avm_write, 1'b0);
    chkb({tag, "_avm_read"}, bus.avm_read, 1'b0);
    chk({tag, "_avm_address"}, 32'(bus.avm_address), 32'h0);
    chk({tag, "_avm_writedata"}, bus.avm_writedata, 32'h0);
    chkb({tag, "_busy"}, bus.busy, 1'b0);
    chkb({tag, "_frame_err"}, bus.frame_err, 1'b0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_n;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.avm_readdata = 32'h0;
    slv_mem[16'h000F] = 32'h1234_5678;
    ref_mem[16'h000F] = 32'h1234_5678;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chkb("rx_ready_after_reset", bus.rx_ready, 1'b1);
    chkb("busy_after_reset", bus.busy, 1'b0);
    @(posedge clk); #1;

    // Directed write with strobe and reply timing
    exp_bus.push_back('{wr: 1'b1, addr: 16'h0005, data: 32'h0000_C350});
    exp_tx.push_back(RSP_ACK);
    ref_mem[16'h0005] = 32'h0000_C350;
    send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hC3, 0);
    send_byte(8'h50, 0);
    @(negedge clk);
    chkb("wr_strobe_timing", bus.avm_write, 1'b1);
    @(negedge clk);
    chkb("wr_ack_valid_timing", bus.tx_valid, 1'b1);
    chk("wr_ack_data", 32'(bus.tx_data), 32'h4B);
    wait_idle();

    // Directed read with strobe, latency and first-byte timing
    exp_bus.push_back('{wr: 1'b0, addr: 16'h000F, data: 32'h0});
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h0F, 0);
    @(negedge clk);
    chkb("rd_strobe_timing", bus.avm_read, 1'b1);
    @(negedge clk);
    chkb("rd_wait_no_valid", bus.tx_valid, 1'b0);
    @(negedge clk);
    chkb("rd_resp_valid_timing", bus.tx_valid, 1'b1);
    chk("rd_resp_first_byte", 32'(bus.tx_data), 32'h12);
    wait_idle();

    // Backpressure during a read response
    bp_hold = 1'b1;
    do_read(16'h0005, 1);
    idle_n = 0;
    while (!bus.tx_valid && idle_n < 50) begin @(negedge clk); idle_n++; end
    chkb("bp_resp_started", bus.tx_valid, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chkb("bp_rx_ready_low", bus.rx_ready, 1'b0);
      chk("bp_first_byte_held", 32'(bus.tx_data), 32'h00);
    end
    bp_hold = 1'b0;
    wait_idle();

    // Unknown command byte
    do_bad(8'h41);
    wait_idle();

    // Inter-byte timeout, then a normal read
    exp_ferr++;
    send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    idle_n = 0;
    while (idle_n < 150) begin
      @(negedge clk);
      idle_n++;
      if (bus.frame_err) break;
    end
    chkb("timeout_fired", bus.frame_err, 1'b1);
    chkb("timeout_at_limit", (idle_n >= 100) && (idle_n <= 101), 1'b1);
    @(negedge clk);
    chkb("timeout_idle_busy", bus.busy, 1'b0);
    chkb("timeout_idle_rx_ready", bus.rx_ready, 1'b1);
    @(posedge clk); #1;
    do_read(16'h0001, 1);
    wait_idle();

    // Reset in the middle of a write frame
    send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chkb("midreset_no_write", bus.avm_write, 1'b0);
    @(posedge clk); #1;
    do_write(16'h0005, 32'hA5A5_0F0F, 1);
    wait_idle();
    do_read(16'h0005, 1);
    wait_idle();

    // Randomized frame mix
    for (int k = 0; k < 40; k++) begin
      int sel;
      logic [15:0] a;
      sel = $urandom_range(0, 6);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      if (sel <= 2)      do_write(a, $urandom, 3);
      else if (sel <= 5) do_read(a, 3);
      else begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == CMD_WR || b == CMD_RD) b = 8'hA0;
        do_bad(b);
      end
    end
    wait_idle();

    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    chk("ferr_drained", 32'(exp_ferr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
